output_port_scheduler: RTL and testbench

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler_pkg.sv | 20 ++
 rtl/output_port_scheduler_rr_pick.sv | 32 +++
 rtl/output_port_scheduler.sv | 94 +++++++++
 tb/tb_output_port_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/output_port_scheduler_pkg.sv
// Shared constants and FSM encoding for the output-port scheduler and
// anything else that arbitrates a router output.
package output_port_scheduler_pkg;

    localparam int NREQ_DEF    = 5;
    localparam int CREDITS_DEF = 4;

    // Input port indices in router order
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr+1,
// wrapping around. sel is one-hot; valid is set when any req bit is set.
module rr_pick
    import output_port_scheduler_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic          valid
);

    logic [PW-1:0] idx;

    // NOTE: every signal driven here gets a default before the loop, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Round-robin, packet-granular output-port scheduler with credit-based
// flow control toward the downstream buffer.
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int CREDITS = CREDITS_DEF,
    parameter int PW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] tail,
    input  logic            credit_in,
    output logic [NREQ-1:0] gnt,
    output logic            fire,
    output logic [CW-1:0]   credit_cnt,
    output logic            credit_err
);

    sched_state_t    state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] pick_sel;
    logic            pick_valid;
    logic            tail_g;

    rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // gnt is all-zero outside BUSY, so fire is naturally 0 in IDLE
    assign fire   = (|(gnt & req)) && (credit_cnt != '0);
    assign tail_g = |(gnt & tail);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= PW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick_sel;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Only the tail flit releases the grant; no preemption
                    if (fire && tail_g) begin
                        ptr   <= gnt_idx;
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({fire, credit_in})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
                    else                            credit_cnt <= credit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a packet-level reference model.
module tb_output_port_scheduler;

    localparam int NREQ    = 5;
    localparam int CREDITS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] tail = '0;
    logic            credit_in = 1'b0;
    logic [NREQ-1:0] gnt;
    logic            fire;
    logic [2:0]      credit_cnt;
    logic            credit_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which port holds the output, last winner, credits
    int m_port  = -1;
    int m_ptr   = NREQ - 1;
    int m_cred  = CREDITS;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    output_port_scheduler #(.NREQ(NREQ), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .gnt        (gnt),
        .fire       (fire),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT with model, advance model
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] t,
                        input logic ci, input logic rs);
        logic [NREQ-1:0] exp_gnt;
        bit              exp_fire;
        @(posedge clk);
        #1;
        req       = r;
        tail      = t;
        credit_in = ci;
        rst       = rs;
        @(negedge clk);
        exp_gnt  = '0;
        exp_fire = 1'b0;
        if (m_port >= 0) begin
            exp_gnt[m_port] = 1'b1;
            exp_fire        = r[m_port] && (m_cred > 0);
        end
        if (m_valid) begin
            check("model_gnt",        32'(gnt),        32'(exp_gnt));
            check("model_fire",       32'(fire),       32'(exp_fire));
            check("model_credit_cnt", 32'(credit_cnt), 32'(m_cred));
            check("model_credit_err", 32'(credit_err), 32'(m_err));
        end
        if (rs) begin
            m_port  = -1;
            m_ptr   = NREQ - 1;
            m_cred  = CREDITS;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_port < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_port < 0 && r[(m_ptr + k) % NREQ]) m_port = (m_ptr + k) % NREQ;
                end
            end else if (exp_fire && t[m_port]) begin
                m_ptr  = m_port;
                m_port = -1;
            end
            if (exp_fire && !ci)      m_cred--;
            else if (ci && !exp_fire) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else                   m_cred++;
            end
        end
    endtask

    initial begin
        // Reset state
        step(5'b00000, 5'b00000, 1'b0, 1'b1);
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        check("reset_gnt",  32'(gnt), 32'h0);
        check("reset_cnt",  32'(credit_cnt), 32'd4);
        check("reset_err",  32'(credit_err), 32'd0);

        // First grant after reset, one-cycle latency
        step(5'b00110, 5'b00000, 1'b0, 1'b0);
        check("grant_latency_gnt", 32'(gnt), 32'h0);
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        check("first_grant_gnt", 32'(gnt), 32'b00010);
        check("first_grant_cnt", 32'(credit_cnt), 32'd4);

        // Port 1 three-flit packet with every port requesting
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        step(5'b11111, 5'b00010, 1'b0, 1'b0);
        check("pkt3_last_fire", 32'(fire), 32'd1);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("bubble_gnt", 32'(gnt), 32'h0);
        check("bubble_cnt", 32'(credit_cnt), 32'd1);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("rr_next_gnt", 32'(gnt), 32'b00100);

        // Credit exhaustion mid-packet and resume
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("stall_fire", 32'(fire), 32'd0);
        check("stall_gnt",  32'(gnt), 32'b00100);
        check("stall_cnt",  32'(credit_cnt), 32'd0);
        step(5'b11111, 5'b00000, 1'b1, 1'b0);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("resume_fire", 32'(fire), 32'd1);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("resume_cnt_zero", 32'(credit_cnt), 32'd0);

        // Simultaneous fire and credit, then overflow at full
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00100, 5'b00000, 1'b1, 1'b0);
        check("both_fire", 32'(fire), 32'd1);
        step(5'b00100, 5'b00100, 1'b0, 1'b0);
        check("both_cnt_held", 32'(credit_cnt), 32'd2);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        check("ovf_cnt", 32'(credit_cnt), 32'd4);
        check("ovf_err", 32'(credit_err), 32'd1);
        for (int i = 0; i < 3; i++) step(5'b01000, 5'b01000, 1'b0, 1'b0);
        check("ovf_err_sticky", 32'(credit_err), 32'd1);

        // Pointer wrap: ptr=4 picks port 0, then port 4
        step(5'b00000, 5'b00000, 1'b0, 1'b1);
        step(5'b10001, 5'b00000, 1'b0, 1'b0);
        step(5'b10001, 5'b00000, 1'b0, 1'b0);
        check("wrap_gnt0", 32'(gnt), 32'b00001);
        step(5'b10001, 5'b00001, 1'b0, 1'b0);
        step(5'b10001, 5'b00000, 1'b0, 1'b0);
        step(5'b10001, 5'b00000, 1'b0, 1'b0);
        check("wrap_gnt4", 32'(gnt), 32'b10000);

        // Reset mid-packet
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        step(5'b11111, 5'b00000, 1'b0, 1'b1);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("midrst_gnt",  32'(gnt), 32'h0);
        check("midrst_fire", 32'(fire), 32'd0);
        check("midrst_cnt",  32'(credit_cnt), 32'd4);
        check("midrst_err",  32'(credit_err), 32'd0);
        step(5'b11111, 5'b00000, 1'b0, 1'b0);
        check("midrst_regrant", 32'(gnt), 32'b00001);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [NREQ-1:0] r;
            logic [NREQ-1:0] t;
            r = NREQ'($urandom_range(0, 31));
            t = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, 31)) : '0;
            step(r, t, ($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
